// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin scheduler that lends one fullHashDES core to N
// byte-stream requesters, one message at a time.
//
// Flow per message: grant an owner, clear the core, program the length
// (hc_c_in), stream the owner's bytes into hc_m/hc_m_valid, wait for
// hc_hash_ready, then hand the digest back with a one-cycle done pulse.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   req[N]             level request per requester, held until done[i]
//   req_len[N*LEN_W]   byte count per requester (slice i)
//   in_valid/in_data   byte stream per requester (in_data slice i is 8 bits)
//   in_ready[N]        byte accepted on in_valid[i] & in_ready[i]
//   grant[N]           one-hot current owner, 0 when idle
//   done[N]            one-cycle completion pulse to the owner
//   done_err           qualifies done: zero length, timeout or abort
//   done_digest        digest while done != 0, 0 on error
//   busy               arbiter not idle
//   hc_*               connection to the hash core
module hash_arbiter #(
  parameter int N       = 4,
  parameter int LEN_W   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*LEN_W-1:0] req_len,
  input  logic [N-1:0]       in_valid,
  input  logic [N*8-1:0]     in_data,
  output logic [N-1:0]       in_ready,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       done,
  output logic               done_err,
  output logic [31:0]        done_digest,
  output logic               busy,
  output logic               hc_clear,
  output logic               hc_m_valid,
  output logic [7:0]         hc_m,
  output logic [LEN_W-1:0]   hc_c_in,
  input  logic               hc_hash_ready,
  input  logic [31:0]        hc_digest
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gidx_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] byte_cnt_r;
  logic [WD_W-1:0]  wdog_r;

  logic             pick_found_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic [LEN_W-1:0] pick_len_s;
  logic             own_req_s;
  logic             hs_s;
  logic [7:0]       cur_byte_s;

  // Round-robin search: first set req bit starting just after the last owner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = ptr_r;
    for (int k = 0; k < N; k++) begin
      if (cand_s == IDX_LAST) begin
        cand_s = '0;
      end else begin
        cand_s = cand_s + IDX_W'(1);
      end
      if (!pick_found_s && req[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Owner-side views: its request level, its handshake and its current byte.
  always_comb begin
    pick_len_s = req_len[pick_idx_s*LEN_W +: LEN_W];
    own_req_s  = |(req & grant);
    hs_s       = |(in_valid & in_ready);
    cur_byte_s = in_data[{gidx_r, 3'b000} +: 8];
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= IDX_LAST;
      gidx_r      <= '0;
      len_r       <= '0;
      byte_cnt_r  <= '0;
      wdog_r      <= '0;
      in_ready    <= '0;
      grant       <= '0;
      done        <= '0;
      done_err    <= 1'b0;
      done_digest <= 32'h0000_0000;
      busy        <= 1'b0;
      hc_clear    <= 1'b0;
      hc_m_valid  <= 1'b0;
      hc_m        <= 8'h00;
      hc_c_in     <= '0;
    end else begin
      // Single-cycle strobes default low.
      hc_clear   <= 1'b0;
      hc_m_valid <= 1'b0;
      done       <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            gidx_r     <= pick_idx_s;
            grant      <= ONE_HOT0 << pick_idx_s;
            len_r      <= pick_len_s;
            hc_c_in    <= pick_len_s;
            hc_clear   <= 1'b1;
            byte_cnt_r <= '0;
            busy       <= 1'b1;
            state_r    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          byte_cnt_r <= '0;
          if (len_r == '0) begin
            done        <= grant;
            done_err    <= 1'b1;
            done_digest <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else begin
            in_ready <= grant;
            state_r  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A dropped request wins over a simultaneous handshake.
          if (!own_req_s) begin
            in_ready    <= '0;
            done        <= grant;
            done_err    <= 1'b1;
            done_digest <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else if (hs_s) begin
            hc_m       <= cur_byte_s;
            hc_m_valid <= 1'b1;
            if (byte_cnt_r == len_r - LEN_ONE) begin
              in_ready <= '0;
              wdog_r   <= '0;
              state_r  <= ST_WAIT;
            end else begin
              byte_cnt_r <= byte_cnt_r + LEN_ONE;
            end
          end
        end
        ST_WAIT: begin
          // wdog_r == 0 marks the first WAIT cycle, when the last byte is
          // still on hc_m and hash_ready cannot yet belong to this message.
          if (!own_req_s) begin
            done        <= grant;
            done_err    <= 1'b1;
            done_digest <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else if ((wdog_r != '0) && hc_hash_ready) begin
            done        <= grant;
            done_err    <= 1'b0;
            done_digest <= hc_digest;
            state_r     <= ST_DONE;
          end else if (wdog_r == WD_LAST) begin
            done        <= grant;
            done_err    <= 1'b1;
            done_digest <= 32'h0000_0000;
            state_r     <= ST_DONE;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        ST_DONE: begin
          ptr_r       <= gidx_r;
          grant       <= '0;
          busy        <= 1'b0;
          done_err    <= 1'b0;
          done_digest <= 32'h0000_0000;
          hc_c_in     <= '0;
          state_r     <= ST_IDLE;
        end
        default: begin
          in_ready <= '0;
          grant    <= '0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
- Round-robin scheduler that shares one fullHashDES core among N byte-stream requesters.
- Per message, the block:
  - grants one requester;
  - clears the core;
  - programs the core length input (C_in);
  - streams the requester's bytes into M/M_valid;
  - waits for hash_ready;
  - returns the 32-bit digest to the granted requester.
- Sits between client engines and the single hash core instance.

Parameters:
- N, 4, number of requesters (2..8).
- LEN_W, 64, width of message length / C_in.
- TIMEOUT, 1024, maximum WAIT cycles before hash_ready is declared missing.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  per-requester message request. Level; held until done[i].
- req_len  in  N*LEN_W  per-requester byte count, slice i. Stable while req[i]=1.
- in_valid  in  N  per-requester byte valid.
- in_data  in  N*8  per-requester byte, slice i.
- in_ready  out  N  byte accepted when in_valid[i]&in_ready[i].
- grant  out  N  one-hot current owner. 0 when idle.
- done  out  N  one-cycle completion pulse to owner.
- done_err  out  1  qualifies done. 1 = zero length, timeout or abort.
- done_digest  out  32  digest, valid while done!=0. 0 on error.
- busy  out  1  state != IDLE.
- hc_clear  out  1  one-cycle core clear (integrator maps to core rst_n).
- hc_m_valid  out  1  core M_valid.
- hc_m  out  8  core M.
- hc_c_in  out  LEN_W  core C_in, held through the whole message.
- hc_hash_ready  in  1  core hash_ready.
- hc_digest  in  32  core digest_final.

Behaviour:
- Reset: every output 0. State IDLE. RR pointer = N-1, so requester 0 wins first.
- FSM states: IDLE, CLEAR, LOAD, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from ptr+1 modulo N.
  - Register grant, latch len = req_len slice, drive hc_c_in = len.
  - Go to CLEAR.
- CLEAR (1 cycle):
  - hc_clear=1, byte counter=0.
  - If len==0, go to DONE with err=1 and the core untouched beyond the clear.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready[g]=1, all other in_ready bits 0.
  - On each handshake, hc_m/hc_m_valid are registered: the byte appears on hc_m one cycle after acceptance, with hc_m_valid=1 for exactly that cycle.
  - Gaps are allowed: hc_m_valid=0 on cycles with no handshake, and hc_m holds its last value.
  - Counter increments per accepted byte.
  - The handshake with counter==len-1 moves to WAIT. in_ready drops in the same cycle as the transition.
- WAIT:
  - hc_hash_ready is ignored in the first WAIT cycle, because the last byte is still on hc_m.
  - From the second cycle on, hash_ready=1 captures hc_digest and goes to DONE with err=0.
  - Watchdog counter reaching TIMEOUT goes to DONE with err=1 and digest=0.
- DONE (1 cycle):
  - done[g]=1, done_err, done_digest driven.
  - ptr=g, grant cleared. Next cycle is IDLE.
- Abort: req[g] falling in LOAD or WAIT goes to DONE with err=1. No further bytes are accepted.
- Minimum turnaround: IDLE→CLEAR→LOAD. The first in_ready is 2 cycles after req is seen.
  - Back-to-back messages cost 1 idle cycle (DONE→IDLE→CLEAR).
- A new req arriving during a transaction waits. Requests from non-owners are never dropped.
- The counter and len are LEN_W wide. No wrap: the counter stops at len-1.
- rst asserted mid-operation: immediate return to the reset state. No done pulse for the lost message.

Test Plan:
1. Single message:
   - Stimulus: req[0] with len=28, bytes "Messaggio in chiaro di prova" (77,101,...,97), continuous valid.
   - Response: hc_c_in=28; hc_clear pulse; 28 hc_m_valid cycles with hc_m equal to the bytes in order; done[0]=1 with done_err=0 and done_digest=hc_digest at the capture cycle.
2. Round-robin fairness:
   - Stimulus: req=4'b1111 right after reset, each len=8.
   - Response: grant order 0,1,2,3. Then re-raise req[0] and req[2] together during requester 3's WAIT: next grant is 0, then 2.
3. Gapped input:
   - Stimulus: len=5, in_valid toggling 1,0,1,0,...
   - Response: exactly 5 hc_m_valid pulses, each one cycle after a handshake. WAIT is entered after the 5th handshake.
4. Zero length and timeout:
   - Stimulus: req[1] with len=0.
   - Response: done[1]=1, done_err=1, no hc_m_valid.
   - Stimulus: stub core with hash_ready stuck 0 and TIMEOUT=16.
   - Response: done_err=1 and digest 0, exactly 16 cycles after WAIT entry.
5. Abort and reset:
   - Stimulus: drop req[2] after 3 of 10 bytes.
   - Response: done[2] with done_err=1, then IDLE.
   - Stimulus: assert rst mid-LOAD.
   - Response: all outputs 0 asynchronously. Next grant is requester 0.
